booth_mul_issue_ctrl: RTL and testbench

Issue and collect stage that wraps the sequential Booth multiplier. It buffers incoming operand pairs in a small FIFO and drives the multiplier's start/operand inputs one job at a time. It waits for the multiplier's done, captures the 2N-bit product and presents it downstream on a valid/ready port. It also polices multiplier latency with a watchdog timer.

---
 rtl/booth_mul_pkg.sv | 27 ++
 rtl/booth_op_fifo.sv | 71 +++++++
 rtl/booth_mul_issue_ctrl.sv | 163 ++++++++++++++++
 tb/tb_booth_mul_issue_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_mul_pkg
// Description : Shared types and default constants for the Booth multiplier
//               issue/collect stage: FSM state encoding and default sizes.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_mul_pkg;

    localparam int c_N_DEFAULT       = 8;
    localparam int c_DEPTH_DEFAULT   = 4;
    localparam int c_TIMEOUT_DEFAULT = 2 * c_N_DEFAULT + 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        CAPT  = 2'd3
    } state_e;

    // Watchdog limit for a multiplier of operand width n.
    function automatic int timeout_for(input int n);
        return 2 * n + 8;
    endfunction

endpackage : booth_mul_pkg
`default_nettype wire

// File: rtl/booth_op_fifo.sv
`default_nettype none
// ============================================================================
// Module      : booth_op_fifo
// Description : Synchronous FIFO for operand pairs. Pointers are one bit
//               wider than the address so full/empty fall out of a plain
//               subtraction.
// Ports       : clk, rst_n       - clock, async active-low reset
//               push, din        - write strobe and data (ignored when full)
//               pop              - read strobe (ignored when empty)
//               dout             - head entry (valid while !empty)
//               full, empty      - occupancy flags
//               count            - number of occupied entries
// Revision    : 1.0 - initial release
// ============================================================================
module booth_op_fifo
    import booth_mul_pkg::*;
#(
    parameter int WIDTH = 2 * c_N_DEFAULT,
    parameter int DEPTH = c_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0]      r_wr_ptr_q, w_wr_ptr_d;
    logic [c_AW:0]      r_rd_ptr_q, w_rd_ptr_d;
    logic [WIDTH-1:0]   r_mem_q [DEPTH];
    logic               w_do_push;
    logic               w_do_pop;

    assign count     = r_wr_ptr_q - r_rd_ptr_q;
    assign full      = (count == (c_AW + 1)'(DEPTH));
    assign empty     = (count == '0);
    assign dout      = r_mem_q[r_rd_ptr_q[c_AW-1:0]];
    // A full FIFO refuses a push even if a pop frees a slot on the same edge.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        if (w_do_push) w_wr_ptr_d = r_wr_ptr_q + 1'b1;
        if (w_do_pop)  w_rd_ptr_d = r_rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem_q[r_wr_ptr_q[c_AW-1:0]] <= din;
    end

endmodule : booth_op_fifo
`default_nettype wire

// File: rtl/booth_mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : booth_mul_issue_ctrl
// Description : Issue/collect wrapper around a sequential Booth multiplier.
//               Buffers operand pairs, issues one job at a time, captures the
//               2N-bit product into a valid/ready result register and aborts
//               jobs whose done does not arrive within TIMEOUT WAIT cycles.
// Ports       : in_valid/in_ready/in_a/in_b  - operand input handshake
//               mul_start/mul_a/mul_b        - multiplier issue interface
//               mul_done/mul_product         - multiplier completion
//               out_valid/out_ready/out_product - result handshake
//               busy, fifo_count, err_timeout - status
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mul_issue_ctrl
    import booth_mul_pkg::*;
#(
    parameter int N       = c_N_DEFAULT,
    parameter int DEPTH   = c_DEPTH_DEFAULT,
    parameter int TIMEOUT = 2 * N + 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0]            in_a,
    input  logic [N-1:0]            in_b,
    output logic                    mul_start,
    output logic [N-1:0]            mul_a,
    output logic [N-1:0]            mul_b,
    input  logic                    mul_done,
    input  logic [2*N-1:0]          mul_product,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*N-1:0]          out_product,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    err_timeout
);

    localparam int              c_TW     = $clog2(TIMEOUT + 1);
    localparam logic [c_TW-1:0] c_T_LAST = c_TW'(TIMEOUT - 1);

    state_e             r_state_q, w_state_d;
    logic [c_TW-1:0]    r_timer_q, w_timer_d;
    logic [N-1:0]       r_mul_a_q, w_mul_a_d;
    logic [N-1:0]       r_mul_b_q, w_mul_b_d;
    logic               r_mul_start_q, w_mul_start_d;
    logic               r_out_valid_q, w_out_valid_d;
    logic [2*N-1:0]     r_out_product_q, w_out_product_d;
    logic               r_err_q, w_err_d;
    logic               r_busy_q, w_busy_d;

    logic               w_fifo_push;
    logic               w_fifo_pop;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [2*N-1:0]     w_fifo_dout;
    logic               w_slot_free;

    booth_op_fifo #(
        .WIDTH (2 * N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_fifo_push),
        .pop   (w_fifo_pop),
        .din   ({in_b, in_a}),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (fifo_count)
    );

    assign in_ready    = !w_fifo_full;
    assign w_fifo_push = in_valid && !w_fifo_full;
    // A held result that is being taken this cycle frees the slot, so the
    // next job can be popped on the same edge as the output transfer.
    assign w_slot_free = !r_out_valid_q || out_ready;

    always_comb begin
        w_state_d       = r_state_q;
        w_timer_d       = r_timer_q;
        w_mul_a_d       = r_mul_a_q;
        w_mul_b_d       = r_mul_b_q;
        w_out_product_d = r_out_product_q;
        w_mul_start_d   = 1'b0;
        w_err_d         = 1'b0;
        w_fifo_pop      = 1'b0;
        w_out_valid_d   = r_out_valid_q && !out_ready;

        case (r_state_q)
            IDLE: begin
                if (!w_fifo_empty && w_slot_free) begin
                    w_fifo_pop    = 1'b1;
                    w_mul_a_d     = w_fifo_dout[N-1:0];
                    w_mul_b_d     = w_fifo_dout[2*N-1:N];
                    w_mul_start_d = 1'b1;
                    w_state_d     = START;
                end
            end
            START: begin
                w_timer_d = '0;
                w_state_d = WAIT;
            end
            WAIT: begin
                if (mul_done) begin
                    w_state_d = CAPT;
                end else if (r_timer_q == c_T_LAST) begin
                    w_err_d   = 1'b1;
                    w_state_d = IDLE;
                end else begin
                    w_timer_d = r_timer_q + 1'b1;
                end
            end
            CAPT: begin
                // The multiplier registers its product, so it is sampled
                // one cycle after done; a new result overrides the clear.
                w_out_product_d = mul_product;
                w_out_valid_d   = 1'b1;
                w_state_d       = IDLE;
            end
            default: w_state_d = IDLE;
        endcase

        w_busy_d = (w_state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q       <= IDLE;
            r_timer_q       <= '0;
            r_mul_a_q       <= '0;
            r_mul_b_q       <= '0;
            r_mul_start_q   <= 1'b0;
            r_out_valid_q   <= 1'b0;
            r_out_product_q <= '0;
            r_err_q         <= 1'b0;
            r_busy_q        <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_timer_q       <= w_timer_d;
            r_mul_a_q       <= w_mul_a_d;
            r_mul_b_q       <= w_mul_b_d;
            r_mul_start_q   <= w_mul_start_d;
            r_out_valid_q   <= w_out_valid_d;
            r_out_product_q <= w_out_product_d;
            r_err_q         <= w_err_d;
            r_busy_q        <= w_busy_d;
        end
    end

    assign mul_start   = r_mul_start_q;
    assign mul_a       = r_mul_a_q;
    assign mul_b       = r_mul_b_q;
    assign out_valid   = r_out_valid_q;
    assign out_product = r_out_product_q;
    assign err_timeout = r_err_q;
    assign busy        = r_busy_q;

endmodule : booth_mul_issue_ctrl
`default_nettype wire

// File: tb/tb_booth_mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_mul_issue_ctrl
// Description : Self-checking bench for booth_mul_issue_ctrl. A behavioural
//               multiplier responds to mul_start after a per-job latency (or
//               never), expected products come from signed integer arithmetic
//               on the operands offered, and results are matched in order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mul_issue_ctrl;

    localparam int c_N       = 8;
    localparam int c_DEPTH   = 4;
    localparam int c_TIMEOUT = 2 * c_N + 8;
    localparam int c_CW      = $clog2(c_DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [c_N-1:0]       in_a, in_b;
    logic                 mul_start;
    logic [c_N-1:0]       mul_a, mul_b;
    logic                 mul_done;
    logic [2*c_N-1:0]     mul_product;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*c_N-1:0]     out_product;
    logic                 busy;
    logic [c_CW-1:0]      fifo_count;
    logic                 err_timeout;

    booth_mul_issue_ctrl #(
        .N       (c_N),
        .DEPTH   (c_DEPTH),
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_done    (mul_done),
        .mul_product (mul_product),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // Reference state: operands/latency in acceptance order, products in
    // completion order. Latency 0 means the multiplier never answers.
    logic [2*c_N-1:0] issue_q[$];
    int               lat_q[$];
    logic [2*c_N-1:0] result_q[$];
    logic [2*c_N-1:0] prod_log[$];

    int n_tests = 0, n_fail = 0;
    int cyc = 0, acc_cyc = 0, start_cyc = 0, done_cyc = 0, rise_cyc = 0;
    int n_starts = 0, n_xfer = 0, n_to_seen = 0, n_to_exp = 0, n_noresp = 0;
    int ready_mode = 0;  // 0 low, 1 high, 2 random

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2*c_N-1:0] ref_prod(input logic [2*c_N-1:0] ops);
        int sa, sb;
        sa = $signed(ops[c_N-1:0]);
        sb = $signed(ops[2*c_N-1:c_N]);
        return (2*c_N)'(sa * sb);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural multiplier.
    initial begin : mul_model
        logic [2*c_N-1:0] ops;
        int  lat, age;
        bit  pend, prev_start, own_done, was_pend;
        pend = 0; prev_start = 0; own_done = 0; lat = 0; age = 0; ops = '0;
        forever begin
            @(negedge clk);
            if (own_done) begin
                mul_done = 1'b0;
                own_done = 0;
            end
            if (!rst_n) begin
                pend = 0;
                prev_start = 0;
                continue;
            end
            was_pend = pend;
            if (pend) begin
                age++;
                if (lat != 0 && age == lat) begin
                    check("hold_a", mul_a, ops[c_N-1:0]);
                    check("hold_b", mul_b, ops[2*c_N-1:c_N]);
                    mul_done    = 1'b1;
                    own_done    = 1;
                    mul_product = ref_prod(ops);
                    result_q.push_back(ref_prod(ops));
                    done_cyc    = cyc;
                    pend        = 0;
                end else if (lat == 0 && age == c_TIMEOUT) begin
                    check("err_early", err_timeout, 1'b0);
                end else if (lat == 0 && age == c_TIMEOUT + 1) begin
                    check("err_at_limit", err_timeout, 1'b1);
                    n_to_exp++;
                    pend = 0;
                end
            end
            if (mul_start) begin
                check("start_single", prev_start, 1'b0);
                check("start_idle", was_pend, 1'b0);
                n_starts++;
                start_cyc = cyc;
                if (issue_q.size() == 0) begin
                    check("start_unexpected", 1, 0);
                end else begin
                    ops = issue_q.pop_front();
                    lat = lat_q.pop_front();
                    check("issue_a", mul_a, ops[c_N-1:0]);
                    check("issue_b", mul_b, ops[2*c_N-1:c_N]);
                    age  = 0;
                    pend = 1;
                end
            end
            prev_start = mul_start;
        end
    end

    // Result consumer: decides out_ready and matches transfers in order.
    initial begin : consumer
        bit prev_v;
        prev_v = 0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                out_ready = 1'b0;
                prev_v = 0;
                continue;
            end
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (out_valid && !prev_v) rise_cyc = cyc;
            prev_v = out_valid;
            if (err_timeout) n_to_seen++;
            if (out_valid && out_ready) begin
                n_xfer++;
                prod_log.push_back(out_product);
                if (result_q.size() == 0) check("result_unexpected", 1, 0);
                else                      check("product", out_product, result_q.pop_front());
            end
        end
    end

    task automatic set_ready(input int m);
        @(posedge clk);
        #1 ready_mode = m;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at a negedge with in_valid low.
    task automatic send(input logic [c_N-1:0] a, input logic [c_N-1:0] b,
                        input int lat, input int max_cyc, output bit ok);
        ok = 0;
        in_valid = 1'b1; in_a = a; in_b = b;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            if (in_ready) begin
                issue_q.push_back({b, a});
                lat_q.push_back(lat);
                if (lat == 0) n_noresp++;
                acc_cyc = cyc + 1;
                ok = 1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int max_cyc);
        bit fin;
        fin = 0;
        for (int i = 0; i < max_cyc && !fin; i++) begin
            @(negedge clk);
            if (issue_q.size() == 0 && result_q.size() == 0 && !busy && !out_valid
                && fifo_count == '0)
                fin = 1;
        end
        check(tag, fin, 1'b1);
    endtask

    initial begin : main
        bit ok;
        int s0, x0, t0;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        mul_done = 1'b0; mul_product = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_mul_start", mul_start, 1'b0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_err", err_timeout, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Spurious done while idle with an empty FIFO.
        mul_done = 1'b1;
        repeat (3) @(negedge clk);
        mul_done = 1'b0;
        check("spur_busy", busy, 1'b0);
        check("spur_out_valid", out_valid, 1'b0);
        check("spur_starts", n_starts, 0);

        // Single job: 3 * -2 with a 10-cycle multiplier.
        set_ready(1);
        s0 = n_starts;
        prod_log.delete();
        send(8'd3, 8'hFE, 10, 50, ok);
        check("single_accept", ok, 1'b1);
        wait_drain("single_drain", 200);
        check("single_starts", n_starts - s0, 1);
        check("single_start_lat", start_cyc - acc_cyc, 1);
        check("single_valid_lat", rise_cyc - done_cyc, 2);
        check("single_nprod", prod_log.size(), 1);
        if (prod_log.size() > 0) check("single_prod", prod_log[0], 16'hFFFA);
        check("single_keep_a", mul_a, 8'h03);
        check("single_keep_b", mul_b, 8'hFE);
        check("single_busy", busy, 1'b0);

        // Fill and stall with the result held.
        set_ready(0);
        s0 = n_starts;
        prod_log.delete();
        for (int i = 1; i <= 5; i++) begin
            send(c_N'(i), c_N'(i), $urandom_range(2, 8), 20, ok);
            check("fill_accept", ok, 1'b1);
        end
        send(8'd6, 8'd6, 3, 5, ok);
        check("fill_refuse6", ok, 1'b0);
        repeat (30) @(negedge clk);
        check("fill_count", fifo_count, 4);
        check("fill_in_ready", in_ready, 1'b0);
        check("fill_held", out_valid, 1'b1);
        check("fill_held_prod", out_product, 1);
        check("fill_busy", busy, 1'b0);
        check("fill_starts", n_starts - s0, 1);
        set_ready(1);
        wait_drain("fill_drain", 500);
        check("fill_nprod", prod_log.size(), 5);
        for (int i = 0; i < 5 && i < prod_log.size(); i++)
            check("fill_order", prod_log[i], (i + 1) * (i + 1));

        // Backpressure: queued job waits for the handshake edge.
        set_ready(0);
        send(8'd5, 8'd7, 4, 20, ok);
        repeat (15) @(negedge clk);
        send(8'd2, 8'd3, 4, 20, ok);
        s0 = n_starts;
        repeat (10) @(negedge clk);
        check("bp_count", fifo_count, 1);
        check("bp_no_start", n_starts - s0, 0);
        set_ready(1);
        check("bp_start_before", mul_start, 1'b0);
        check("bp_count_before", fifo_count, 1);
        @(negedge clk);
        check("bp_start_after", mul_start, 1'b1);
        check("bp_count_after", fifo_count, 0);
        wait_drain("bp_drain", 200);

        // Timeout followed by a normal job.
        t0 = n_to_seen; x0 = n_xfer;
        send(8'd9, 8'd9, 0, 20, ok);
        send(8'd4, 8'd5, 5, 20, ok);
        wait_drain("to_drain", 300);
        check("to_pulses", n_to_seen - t0, 1);
        check("to_results", n_xfer - x0, 1);

        // Reset during WAIT with jobs still queued.
        s0 = n_starts;
        send(8'd7, 8'd7, 0, 20, ok);
        send(8'd1, 8'd2, 3, 20, ok);
        send(8'd2, 8'd2, 3, 20, ok);
        for (int i = 0; i < 50 && n_starts == s0; i++) @(negedge clk);
        check("rw_started", n_starts - s0, 1);
        n_noresp--;  // that job is aborted by reset, not by the watchdog
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rw_out_valid", out_valid, 1'b0);
        check("rw_busy", busy, 1'b0);
        check("rw_mul_start", mul_start, 1'b0);
        check("rw_fifo_count", fifo_count, 0);
        check("rw_err", err_timeout, 1'b0);
        check("rw_out_product", out_product, 0);
        check("rw_mul_a", mul_a, 0);
        issue_q.delete(); lat_q.delete(); result_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s0 = n_starts;
        @(negedge clk);
        mul_done = 1'b1;
        repeat (3) @(negedge clk);
        mul_done = 1'b0;
        check("rw_late_done_busy", busy, 1'b0);
        check("rw_late_done_valid", out_valid, 1'b0);
        check("rw_late_done_start", n_starts - s0, 0);

        // Randomised traffic with random backpressure and occasional hangs.
        set_ready(2);
        for (int j = 0; j < 60; j++) begin
            int lat;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
            send(c_N'($urandom), c_N'($urandom), lat, 400, ok);
            check("rand_accept", ok, 1'b1);
        end
        wait_drain("rand_drain", 4000);
        check("timeouts_total", n_to_seen, n_noresp);
        check("timeouts_model", n_to_exp, n_noresp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_booth_mul_issue_ctrl
`default_nettype wire
